// File: rtl/sccb_pkg.sv
// sccb_pkg: shared types and constants for the multi-channel SCCB configurator.
//   state_e  - top-level sequencer states
//   phase_e  - byte-engine bus phases
//   END_MARK / DELAY_MARK - special ROM words
package sccb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_XFER    = 3'd3,
        ST_DELAY   = 3'd4,
        ST_NEXT_CH = 3'd5,
        ST_FIN     = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_START = 3'd1,
        PH_BIT   = 3'd2,
        PH_STOP  = 3'd3,
        PH_GAP   = 3'd4
    } phase_e;

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARK = 16'hFFF0;

endpackage

// File: rtl/sccb_byte_engine.sv
// sccb_byte_engine: one complete SCCB 3-phase write on a single bus.
//   START, 3 x (8 data bits MSB first + released 9th bit), STOP, then one
//   idle SCL period so back-to-back writes (including retries) are spaced.
// Ports:
//   clk_i, reset_i      - clock, synchronous active-high reset
//   go_i                - one-cycle request; bytes_i is captured with it
//   bytes_i[23:0]       - {device address, register, value}
//   sda_i               - SDA line as seen on the bus (for ACK sampling)
//   scl_o, sda_oe_o     - SCL level and SDA pull-low enable
//   done_o, nack_o      - done pulses once per write; nack_o valid with it
module sccb_byte_engine
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        go_i,
    input  logic [23:0] bytes_i,
    input  logic        sda_i,
    output logic        scl_o,
    output logic        sda_oe_o,
    output logic        done_o,
    output logic        nack_o
);

    localparam int            DW       = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    phase_e        phase_q;
    logic [DW-1:0] div_q;
    logic [1:0]    qtr_q;
    logic [3:0]    bit_q;
    logic [1:0]    byte_q;
    logic [23:0]   shift_q;
    logic          scl_q;
    logic          oe_q;
    logic          done_q;
    logic          nack_q;
    logic          tick_s;

    // One enable every CLK_DIV clocks marks a quarter of an SCL period.
    assign tick_s = (div_q == DIV_LAST);

    assign scl_o    = scl_q;
    assign sda_oe_o = oe_q;
    assign done_o   = done_q;
    assign nack_o   = nack_q;

    // Bus sequencer: quarter 0 sets SDA (SCL low), 1 raises SCL,
    // 2 samples the ACK at the middle of SCL high, 3 lowers SCL.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            phase_q <= PH_IDLE;
            div_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 4'd0;
            byte_q  <= 2'd0;
            shift_q <= 24'd0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (phase_q == PH_IDLE) begin
                div_q <= '0;
                qtr_q <= 2'd0;
                if (go_i) begin
                    phase_q <= PH_START;
                    shift_q <= bytes_i;
                    nack_q  <= 1'b0;
                    bit_q   <= 4'd0;
                    byte_q  <= 2'd0;
                end
            end else begin
                div_q <= tick_s ? '0 : div_q + 1'b1;
                if (tick_s) begin
                    qtr_q <= qtr_q + 2'd1;
                    case (phase_q)
                        PH_START: begin
                            case (qtr_q)
                                2'd0:    oe_q    <= 1'b1;   // SDA falls while SCL high
                                2'd1:    scl_q   <= 1'b0;
                                2'd3:    phase_q <= PH_BIT;
                                default: begin end
                            endcase
                        end
                        PH_BIT: begin
                            case (qtr_q)
                                2'd0:    oe_q  <= (bit_q == 4'd8) ? 1'b0 : ~shift_q[23];
                                2'd1:    scl_q <= 1'b1;
                                2'd2: begin
                                    if ((bit_q == 4'd8) && sda_i) begin
                                        nack_q <= 1'b1;
                                    end
                                end
                                2'd3: begin
                                    scl_q <= 1'b0;
                                    if (bit_q == 4'd8) begin
                                        bit_q <= 4'd0;
                                        if (byte_q == 2'd2) begin
                                            phase_q <= PH_STOP;
                                        end else begin
                                            byte_q <= byte_q + 2'd1;
                                        end
                                    end else begin
                                        bit_q   <= bit_q + 4'd1;
                                        shift_q <= {shift_q[22:0], 1'b0};
                                    end
                                end
                                default: begin end
                            endcase
                        end
                        PH_STOP: begin
                            case (qtr_q)
                                2'd0:    oe_q    <= 1'b1;
                                2'd1:    scl_q   <= 1'b1;
                                2'd2:    oe_q    <= 1'b0;   // SDA rises while SCL high
                                2'd3:    phase_q <= PH_GAP;
                                default: begin end
                            endcase
                        end
                        PH_GAP: begin
                            if (qtr_q == 2'd3) begin
                                phase_q <= PH_IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                        default: phase_q <= PH_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/sccb_multi_cfg.sv
// sccb_multi_cfg: configures NUM_CAM sensors in turn from one shared ROM,
// using a single shared byte engine demultiplexed onto per-channel buses.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   start            - pulse to configure all channels from channel 0
//   rom_addr/rom_data- external ROM, data valid one clk after address
//   scl[]/sda[]      - per-channel SCCB bus (SDA open-drain)
//   busy, done       - run in progress / one-cycle completion pulse
//   ch_err[]         - sticky: a write on that channel ran out of retries
module sccb_multi_cfg
    import sccb_pkg::*;
#(
    parameter int          NUM_CAM   = 2,
    parameter int          CLK_DIV   = 250,
    parameter logic [7:0]  DEV_ADDR  = 8'h42,
    parameter int          ROM_AW    = 8,
    parameter int          MAX_RETRY = 2,
    parameter int          DELAY_CYC = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [15:0]         rom_data,
    output logic [NUM_CAM-1:0]  scl,
    inout  wire  [NUM_CAM-1:0]  sda,
    output logic                busy,
    output logic                done,
    output logic [NUM_CAM-1:0]  ch_err
);

    localparam int             CHW        = (NUM_CAM > 1) ? $clog2(NUM_CAM) : 1;
    localparam int             RW         = $clog2(MAX_RETRY + 2);
    localparam int             DLW        = $clog2(DELAY_CYC + 1);
    localparam logic [CHW-1:0] CH_LAST    = CHW'(NUM_CAM - 1);
    localparam logic [RW-1:0]  RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [DLW-1:0] DELAY_LAST = DLW'(DELAY_CYC - 1);

    state_e              state_q;
    logic [CHW-1:0]      ch_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic [RW-1:0]       retry_q;
    logic [DLW-1:0]      delay_q;
    logic [15:0]         entry_q;
    logic                busy_q;
    logic                done_q;
    logic                go_q;
    logic [NUM_CAM-1:0]  ch_err_q;

    logic                addr_last_s;
    logic [ROM_AW-1:0]   addr_inc_d;
    logic [NUM_CAM-1:0]  sda_in_s;
    logic                eng_scl_s;
    logic                eng_oe_s;
    logic                eng_done_s;
    logic                eng_nack_s;

    // Stepping past the all-ones address is a wrap and ends the channel.
    assign addr_last_s = &rom_addr_q;
    assign addr_inc_d  = rom_addr_q + 1'b1;
    assign sda_in_s    = sda;

    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ch_err   = ch_err_q;

    sccb_byte_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk_i    (clk),
        .reset_i  (reset),
        .go_i     (go_q),
        .bytes_i  ({DEV_ADDR, entry_q}),
        .sda_i    (sda_in_s[ch_q]),
        .scl_o    (eng_scl_s),
        .sda_oe_o (eng_oe_s),
        .done_o   (eng_done_s),
        .nack_o   (eng_nack_s)
    );

    // Only the selected channel sees the engine; others idle at SCL=1, SDA=Z.
    for (genvar g = 0; g < NUM_CAM; g++) begin : g_bus
        assign scl[g] = (ch_q == CHW'(g)) ? eng_scl_s : 1'b1;
        assign sda[g] = ((ch_q == CHW'(g)) && eng_oe_s) ? 1'b0 : 1'bz;
    end

    // Configuration sequencer: ROM walk per channel, retries, delays.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            rom_addr_q <= '0;
            retry_q    <= '0;
            delay_q    <= '0;
            entry_q    <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            go_q       <= 1'b0;
            ch_err_q   <= '0;
        end else begin
            done_q <= 1'b0;
            go_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        ch_q       <= '0;
                        rom_addr_q <= '0;
                        ch_err_q   <= '0;
                        state_q    <= ST_FETCH;
                    end
                end
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (rom_data == END_MARK) begin
                        state_q <= ST_NEXT_CH;
                    end else if (rom_data == DELAY_MARK) begin
                        delay_q <= '0;
                        state_q <= ST_DELAY;
                    end else begin
                        entry_q <= rom_data;
                        retry_q <= '0;
                        go_q    <= 1'b1;
                        state_q <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eng_done_s) begin
                        if (eng_nack_s && (retry_q < RETRY_MAX)) begin
                            retry_q <= retry_q + 1'b1;
                            go_q    <= 1'b1;
                        end else begin
                            if (eng_nack_s) begin
                                ch_err_q[ch_q] <= 1'b1;
                            end
                            rom_addr_q <= addr_inc_d;
                            state_q    <= addr_last_s ? ST_NEXT_CH : ST_FETCH;
                        end
                    end
                end
                ST_DELAY: begin
                    if (delay_q == DELAY_LAST) begin
                        rom_addr_q <= addr_inc_d;
                        state_q    <= addr_last_s ? ST_NEXT_CH : ST_FETCH;
                    end else begin
                        delay_q <= delay_q + 1'b1;
                    end
                end
                ST_NEXT_CH: begin
                    rom_addr_q <= '0;
                    if (ch_q == CH_LAST) begin
                        state_q <= ST_FIN;
                    end else begin
                        ch_q    <= ch_q + 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ch_q    <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_multi_cfg.sv
// Directed bench for sccb_multi_cfg: sensor models decode each bus and
// ACK/NACK as told; expected frames and flags are hand-computed constants.
module tb_sccb_multi_cfg;

    localparam int NC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    rom_addr;
    logic [15:0]   rom_data = 16'd0;
    logic [NC-1:0] scl;
    wire  [NC-1:0] sda;
    logic          busy;
    logic          done;
    logic [NC-1:0] ch_err;

    logic [15:0]   rom_mem [16];
    logic [NC-1:0] sen_drv = '0;
    int            mode [NC];
    logic          mon_clr = 1'b0;
    longint        cyc = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    // sensor / monitor state
    logic          prev_scl [NC];
    logic          prev_sda [NC];
    int            bit_cnt  [NC];
    int            byte_idx [NC];
    logic [7:0]    shf      [NC];
    logic [23:0]   acc      [NC];
    logic          acked    [NC];
    logic [23:0]   frm_data [NC][32];
    logic          frm_ack  [NC][32];
    longint        t_start  [NC][32];
    longint        t_stop   [NC][32];
    int            frm_cnt  [NC];
    int            done_cnt;

    sccb_multi_cfg #(
        .NUM_CAM   (NC),
        .CLK_DIV   (2),
        .DEV_ADDR  (8'h42),
        .ROM_AW    (4),
        .MAX_RETRY (2),
        .DELAY_CYC (1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .scl      (scl),
        .sda      (sda),
        .busy     (busy),
        .done     (done),
        .ch_err   (ch_err)
    );

    for (genvar g = 0; g < NC; g++) begin : g_sen
        pullup pu (sda[g]);
        assign sda[g] = sen_drv[g] ? 1'b0 : 1'bz;
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom_mem[rom_addr];
    end

    // Sensor models and bus monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (reset || mon_clr) begin
            done_cnt = 0;
            for (int c = 0; c < NC; c++) begin
                prev_scl[c] = 1'b1; prev_sda[c] = 1'b1;
                bit_cnt[c] = 0; byte_idx[c] = 0; frm_cnt[c] = 0;
                acked[c] = 1'b1; sen_drv[c] = 1'b0;
            end
        end else begin
            if (done) done_cnt++;
            for (int c = 0; c < NC; c++) begin
                logic cs, ds;
                cs = scl[c];
                ds = sda[c];
                if (prev_scl[c] && cs && prev_sda[c] && !ds) begin
                    bit_cnt[c] = 0; byte_idx[c] = 0; acked[c] = 1'b1; sen_drv[c] = 1'b0;
                    if (frm_cnt[c] < 32) t_start[c][frm_cnt[c]] = cyc;
                end else if (prev_scl[c] && cs && !prev_sda[c] && ds) begin
                    if (byte_idx[c] == 3 && frm_cnt[c] < 32) begin
                        frm_data[c][frm_cnt[c]] = acc[c];
                        frm_ack[c][frm_cnt[c]]  = acked[c];
                        t_stop[c][frm_cnt[c]]   = cyc;
                        frm_cnt[c]++;
                    end
                    byte_idx[c] = 0;
                end else if (!prev_scl[c] && cs) begin
                    if (bit_cnt[c] < 8) begin
                        shf[c] = {shf[c][6:0], ds};
                        bit_cnt[c]++;
                    end
                end else if (prev_scl[c] && !cs) begin
                    if (bit_cnt[c] == 8) begin
                        if (mode[c] == 1 || (mode[c] == 2 && frm_cnt[c] == 0)) acked[c] = 1'b0;
                        else sen_drv[c] = 1'b1;
                        bit_cnt[c] = 9;
                    end else if (bit_cnt[c] == 9) begin
                        sen_drv[c] = 1'b0;
                        acc[c] = {acc[c][15:0], shf[c]};
                        byte_idx[c]++;
                        bit_cnt[c] = 0;
                    end
                end
                prev_scl[c] = cs;
                prev_sda[c] = ds;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, (n < 20000), 1);
        repeat (20) @(negedge clk);
    endtask

    task automatic rom_fill_end();
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'hFFFF;
    endtask

    initial begin
        longint gap;
        int     n;
        for (int c = 0; c < NC; c++) mode[c] = 0;
        rom_fill_end();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        check_eq("rst_scl", scl, 2'b11);
        check_eq("rst_sda", sda, 2'b11);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", ch_err, 0);
        check_eq("rst_addr", rom_addr, 0);

        // two writes per channel, start reissued while busy
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1204; rom_mem[2] = 16'hFFFF;
        clear_mon();
        pulse_start();
        repeat (40) @(negedge clk);
        check_eq("t1_busy", busy, 1);
        pulse_start();
        wait_done("t1_timeout");
        check_eq("t1_c0_cnt", frm_cnt[0], 2);
        check_eq("t1_c1_cnt", frm_cnt[1], 2);
        check_eq("t1_c0_w0", frm_data[0][0], 24'h421280);
        check_eq("t1_c0_w1", frm_data[0][1], 24'h421204);
        check_eq("t1_c1_w0", frm_data[1][0], 24'h421280);
        check_eq("t1_c1_w1", frm_data[1][1], 24'h421204);
        check_eq("t1_order", (t_start[1][0] > t_stop[0][1]), 1);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_err", ch_err, 2'b00);
        check_eq("t1_busy_end", busy, 0);

        // delay entry between the two writes
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'hFFF0; rom_mem[2] = 16'h1204; rom_mem[3] = 16'hFFFF;
        clear_mon();
        pulse_start();
        wait_done("t2_timeout");
        check_eq("t2_c0_cnt", frm_cnt[0], 2);
        check_eq("t2_c0_w1", frm_data[0][1], 24'h421204);
        gap = t_start[0][1] - t_stop[0][0];
        check_eq("t2_gap_ge_1000", (gap >= 1000), 1);

        // channel 1 always NACKs
        rom_fill_end();
        rom_mem[0] = 16'h1280; rom_mem[1] = 16'h1204;
        mode[1] = 1;
        clear_mon();
        pulse_start();
        wait_done("t3_timeout");
        check_eq("t3_c0_cnt", frm_cnt[0], 2);
        check_eq("t3_c0_ack", frm_ack[0][0], 1);
        check_eq("t3_c1_cnt", frm_cnt[1], 6);
        check_eq("t3_c1_w2", frm_data[1][2], 24'h421280);
        check_eq("t3_c1_w3", frm_data[1][3], 24'h421204);
        check_eq("t3_c1_ack", frm_ack[1][0], 0);
        check_eq("t3_err", ch_err, 2'b10);
        check_eq("t3_done_cnt", done_cnt, 1);

        // channel 0 NACKs its first attempt only; ch_err clears on start
        rom_fill_end();
        rom_mem[0] = 16'h1280;
        mode[0] = 2; mode[1] = 0;
        clear_mon();
        pulse_start();
        repeat (3) @(negedge clk);
        check_eq("t4_err_clr", ch_err, 2'b00);
        wait_done("t4_timeout");
        check_eq("t4_c0_cnt", frm_cnt[0], 2);
        check_eq("t4_c0_ack1", frm_ack[0][1], 1);
        check_eq("t4_c1_cnt", frm_cnt[1], 1);
        check_eq("t4_err", ch_err, 2'b00);
        mode[0] = 0;

        // reset during the second byte, then a fresh start
        clear_mon();
        pulse_start();
        n = 0;
        while (!(byte_idx[0] == 1 && bit_cnt[0] == 3) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_reach_byte2", (n < 5000), 1);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check_eq("t5_scl", scl, 2'b11);
        check_eq("t5_sda", sda, 2'b11);
        check_eq("t5_busy", busy, 0);
        clear_mon();
        pulse_start();
        wait_done("t5_timeout");
        check_eq("t5_c0_cnt", frm_cnt[0], 1);
        check_eq("t5_c0_w0", frm_data[0][0], 24'h421280);
        check_eq("t5_c1_cnt", frm_cnt[1], 1);

        // ROM without end mark wraps and ends each channel
        for (int i = 0; i < 16; i++) rom_mem[i] = 16'h3300 + 16'(i);
        clear_mon();
        pulse_start();
        wait_done("t6_timeout");
        check_eq("t6_c0_cnt", frm_cnt[0], 16);
        check_eq("t6_c1_cnt", frm_cnt[1], 16);
        check_eq("t6_c0_last", frm_data[0][15], 24'h42330F);
        check_eq("t6_c1_first", frm_data[1][0], 24'h423300);
        check_eq("t6_err", ch_err, 2'b00);
        check_eq("t6_done_cnt", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
